// File: rtl/clk_div_monitor.sv
// Period monitor for a divided clock in the same clk domain.
// Measures rise-to-rise distance, tracks lock and sticky fault status.
module clk_div_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 5,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4,
  parameter int FAULT_CNT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             fault
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ACQUIRE = 3'd1;
  localparam logic [2:0] TRACK   = 3'd2;
  localparam logic [2:0] LOCKED  = 3'd3;
  localparam logic [2:0] FAULT   = 3'd4;

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(FAULT_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0] LO =
    (CNT_W+1)'(EXP_PERIOD - TOL);
  localparam logic [CNT_W:0] HI =
    (CNT_W+1)'(EXP_PERIOD + TOL);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_CNT);
  localparam logic [BW-1:0] FAULT_N = BW'(FAULT_CNT);

  logic             s1;
  logic             s2;
  logic             rise;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0]    good_cnt;
  logic [BW-1:0]    bad_cnt;
  logic             timeout;
  logic             evt;
  logic             good;
  logic [CNT_W:0]   meas;
  logic [CNT_W-1:0] meas_out;

  assign rise    = s1 & ~s2;
  assign timeout = (cnt == CNT_MAX) & ~rise;
  assign evt     = rise | timeout;

  // One extra bit so a rise at cnt==max is not misread as a tiny period
  assign meas = rise ? ({1'b0, cnt} + (CNT_W+1)'(1))
                     : {1'b0, CNT_MAX};
  assign meas_out = meas[CNT_W] ? CNT_MAX : meas[CNT_W-1:0];
  assign good     = (meas >= LO) && (meas <= HI);

  assign locked = (state == LOCKED);
  assign fault  = (state == FAULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= div_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state        <= IDLE;
      cnt          <= '0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          good_cnt <= '0;
          bad_cnt  <= '0;
          period   <= '0;
          state    <= ACQUIRE;
        end
        ACQUIRE: begin
          cnt <= '0;
          // First rise is only a reference edge
          if (rise) state <= TRACK;
        end
        TRACK, LOCKED, FAULT: begin
          cnt <= evt ? '0 : cnt + CNT_W'(1);
          if (evt) begin
            period       <= meas_out;
            period_valid <= 1'b1;
            if (state == TRACK) begin
              if (!good) begin
                good_cnt <= '0;
              end else if (good_cnt + GW'(1) == LOCK_N) begin
                good_cnt <= '0;
                state    <= LOCKED;
              end else begin
                good_cnt <= good_cnt + GW'(1);
              end
            end else if (state == LOCKED) begin
              if (good) begin
                bad_cnt <= '0;
              end else if (bad_cnt + BW'(1) == FAULT_N) begin
                bad_cnt <= '0;
                state   <= FAULT;
              end else begin
                bad_cnt <= bad_cnt + BW'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: lock, fault, tolerance,
// reset/enable handling and timeout on a narrow-counter instance.
module tb_clk_div_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       div_in;
  logic [7:0] period;
  logic       period_valid;
  logic       locked;
  logic       fault;
  logic [3:0] period_b;
  logic       period_valid_b;
  logic       locked_b;
  logic       fault_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_div_monitor u_dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .div_in       (div_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .fault        (fault)
  );

  clk_div_monitor #(.CNT_W(4)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .div_in       (div_in),
    .period       (period_b),
    .period_valid (period_valid_b),
    .locked       (locked_b),
    .fault        (fault_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d);
    div_in = d;
    @(posedge clk);
    #1;
  endtask

  // One period of length p; the pulse seen inside it measures the
  // previous period (ep).
  task automatic per(input int p, input int expv, input int ep,
                     input int el, input int ef);
    int hi;
    hi = (p > 3) ? 3 : p - 1;
    for (int i = 0; i < p; i++) begin
      step(i < hi);
      if (i == 1) begin
        chk("valid", int'(period_valid), expv);
        if (expv != 0) chk("period", int'(period), ep);
        chk("locked", int'(locked), el);
        chk("fault", int'(fault), ef);
      end
      if (i == 2) chk("valid_off", int'(period_valid), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("rst_period", int'(period), 0);
    chk("rst_valid", int'(period_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_b_locked", int'(locked_b), 0);
    chk("rst_b_fault", int'(fault_b), 0);

    // Clean period-5: lock on the 4th pulse
    rst = 1'b0;
    en  = 1'b1;
    step(1'b0);
    per(5, 0, 0, 0, 0);
    per(5, 1, 5, 0, 0);
    per(5, 1, 5, 0, 0);
    per(5, 1, 5, 0, 0);
    per(5, 1, 5, 1, 0);

    // Two 7-cycle periods after lock -> fault, sticky
    per(7, 1, 5, 1, 0);
    per(7, 1, 7, 1, 0);
    per(5, 1, 7, 0, 1);
    chk("b_fault", int'(fault_b), 1);
    per(5, 1, 5, 0, 1);
    per(5, 1, 5, 0, 1);

    // en low clears; level high at enable is not a rise
    en = 1'b0;
    step(1'b1);
    chk("idle_locked", int'(locked), 0);
    chk("idle_fault", int'(fault), 0);
    chk("idle_period", int'(period), 0);
    chk("idle_valid", int'(period_valid), 0);
    step(1'b1);
    en = 1'b1;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    per(5, 0, 0, 0, 0);
    per(5, 1, 5, 0, 0);
    per(5, 1, 5, 0, 0);
    per(5, 1, 5, 0, 0);
    // Isolated short periods do not fault
    per(4, 1, 5, 1, 0);
    per(5, 1, 4, 1, 0);
    per(5, 1, 5, 1, 0);
    per(4, 1, 5, 1, 0);
    per(5, 1, 4, 1, 0);
    per(5, 1, 5, 1, 0);

    // Period-6 never locks
    en = 1'b0;
    step(1'b0);
    en = 1'b1;
    step(1'b0);
    per(6, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) per(6, 1, 6, 0, 0);

    // Reset mid-TRACK with a rise pending
    step(1'b1);
    rst = 1'b1;
    step(1'b1);
    chk("mrst_period", int'(period), 0);
    chk("mrst_valid", int'(period_valid), 0);
    chk("mrst_locked", int'(locked), 0);
    chk("mrst_fault", int'(fault), 0);
    rst = 1'b0;
    step(1'b0);
    per(5, 0, 0, 0, 0);
    per(5, 1, 5, 0, 0);
    per(5, 1, 5, 0, 0);
    per(5, 1, 5, 0, 0);
    per(5, 1, 5, 1, 0);

    // Drop en while locked, then relock from scratch
    en = 1'b0;
    step(1'b0);
    chk("den_locked", int'(locked), 0);
    en = 1'b1;
    step(1'b0);
    per(5, 0, 0, 0, 0);
    per(5, 1, 5, 0, 0);
    per(5, 1, 5, 0, 0);
    per(5, 1, 5, 0, 0);
    per(5, 1, 5, 1, 0);
    chk("b_locked", int'(locked_b), 1);

    // div_in stuck low: CNT_W=4 instance times out every 16 cycles
    for (int i = 0; i < 12; i++) step(1'b0);
    chk("to1_pre_valid", int'(period_valid_b), 0);
    step(1'b0);
    chk("to1_valid", int'(period_valid_b), 1);
    chk("to1_period", int'(period_b), 15);
    chk("to1_locked", int'(locked_b), 1);
    chk("to1_fault", int'(fault_b), 0);
    chk("to1_a_valid", int'(period_valid), 0);
    for (int i = 0; i < 15; i++) step(1'b0);
    chk("to2_pre_valid", int'(period_valid_b), 0);
    step(1'b0);
    chk("to2_valid", int'(period_valid_b), 1);
    chk("to2_period", int'(period_b), 15);
    chk("to2_locked", int'(locked_b), 0);
    chk("to2_fault", int'(fault_b), 1);
    chk("to2_a_locked", int'(locked), 1);
    chk("to2_a_fault", int'(fault), 0);
    en = 1'b0;
    step(1'b0);
    chk("end_b_fault", int'(fault_b), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Period monitor for a divided clock produced by the ring-counter dividers. It sits directly downstream of a divider in the same `clk` domain. It samples the divided output, measures the distance between successive rising edges in `clk` cycles, and reports each period. It also asserts `locked` after a run of in-tolerance periods and a sticky `fault` when the divider misbehaves after lock, including a stuck output. Integration uses it as the health check on each divider instance.

## Interface
- `CNT_W`, default 8: width of the period counter and of `period`.
- `EXP_PERIOD`, default 5: expected divide ratio in `clk` cycles.
- `TOL`, default 0: allowed deviation. A period is good when it lies in [EXP_PERIOD-TOL, EXP_PERIOD+TOL].
- `LOCK_CNT`, default 4: consecutive good periods required to lock.
- `FAULT_CNT`, default 2: consecutive bad periods after lock that set `fault`.
- Parameter rule: EXP_PERIOD+TOL < 2^CNT_W-1, EXP_PERIOD-TOL ≥ 2, LOCK_CNT ≥ 1, FAULT_CNT ≥ 1.
- `clk` in 1: single clock, rising edge. The divider runs on this clock too.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: enables monitoring. Low forces IDLE.
- `div_in` in 1: divided clock under test, sampled as data.
- `period` out CNT_W: last measured period.
- `period_valid` out 1: one-cycle pulse when `period` updates.
- `locked` out 1: lock status.
- `fault` out 1: sticky fault flag.

## Operation
- Edge detect: `s1 <= div_in` and `s2 <= s1` every cycle, regardless of `en`. `rise = s1 & ~s2`.
- Counter `cnt`:
  - Clears to 0 on `rise`, otherwise increments.
  - Held at 0 in IDLE and ACQUIRE.
- Measurement: on `rise` in TRACK or LOCKED, set `period <= cnt+1` and pulse `period_valid`. Rises at cycles t0 and t1 give `period` = t1-t0.
- Timeout: in TRACK or LOCKED, if `cnt == 2^CNT_W-1` and there is no `rise`:
  - `period <= 2^CNT_W-1`, `period_valid` pulses, and the event counts as bad.
  - `cnt <= 0`.
- FSM states are IDLE, ACQUIRE, TRACK, LOCKED and FAULT.
  - IDLE: entered on `rst` or `en=0`, from any state. With `en=1`, go to ACQUIRE.
  - ACQUIRE: waits for the first `rise`, which is a reference edge only (no measurement). Then go to TRACK.
  - TRACK:
    - Good measurement: `good_cnt++`. When it reaches LOCK_CNT, go to LOCKED and clear `good_cnt`.
    - Bad measurement: `good_cnt <= 0`, stay in TRACK.
  - LOCKED:
    - Good measurement: `bad_cnt <= 0`.
    - Bad measurement: `bad_cnt++`. When it reaches FAULT_CNT, go to FAULT.
  - FAULT: absorbing. Exit only via `rst` or `en=0`. Measurements and `period_valid` continue.
- `locked` = (state==LOCKED). `fault` = (state==FAULT). Both are registered with the state.
- `en=0` has priority over every event. `rst` has priority over `en`.

## Timing
- Reset values: `period`=0, `period_valid`=0, `locked`=0, `fault`=0, s1/s2/cnt/good_cnt/bad_cnt=0, state=IDLE.
- IDLE clears `period` to 0, `cnt`, `good_cnt` and `bad_cnt`. s1/s2 keep sampling, so a level already high at enable is not a rise.
- Latency: if `div_in` is first sampled high at edge k, then `rise` is true during cycle k→k+1. At edge k+1 the block updates `period`, `period_valid`, the counters and the state.
- `locked` rises in the same cycle as the `period_valid` of the LOCK_CNT-th good period.
- `fault` rises, and `locked` falls, in the same cycle as the `period_valid` of the FAULT_CNT-th bad period.
- Defaults: with a clean period-5 input, lock comes at the 5th rise after entering ACQUIRE.
- Timeout fires 2^CNT_W cycles after the last `rise` or the last timeout.
- `rise` and the timeout in the same cycle: `rise` wins and the measurement is a normal one.
- `rst` mid-operation: all outputs are 0 after the next edge and no partial measurement is kept.

## Test plan
- Defaults, `div_in` pattern 1,1,1,0,0 repeating, `en=1`:
  - `period_valid` pulses every 5 cycles with `period=5`.
  - `locked=1` on the 4th pulse.
  - `fault` stays 0.
- Period-6 input, TOL=0: `period=6` on each pulse, `locked` never asserts, `fault=0`.
- Lock, then two consecutive 7-cycle periods: `fault=1` and `locked=0` at the 2nd `period_valid`. Both hold through later good periods until `en=0`.
- Lock, then one period of 4 followed by periods of 5: `locked` stays 1 and `fault` stays 0.
- CNT_W=4, lock, then `div_in` held low:
  - Pulses of `period=15` arrive 16 cycles apart.
  - `fault=1` at the 2nd pulse.
- `rst` asserted mid-TRACK: all outputs 0 the following cycle. `en` dropped mid-LOCKED: `locked=0` next cycle. Re-enabling needs a fresh reference edge plus 4 good periods to relock.
